// File: rtl/i2s_receiver.sv
// I2S slave receiver: oversamples codec SCLK/LRCLK/SDATA on clk and deserialises stereo words.
// Latency: o_valid rises 4 clk after the codec SCLK edge that carries the right-channel LSB.
// Backpressure: one-entry output buffer held until i_ready; a frame completing while full is dropped (o_overrun).
module i2s_receiver #(
    parameter int DATA_WIDTH = 24,
    parameter int SLOT_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i2s_sclk,
    input  logic                  i2s_lrclk,
    input  logic                  i2s_sdata,
    output logic [DATA_WIDTH-1:0] o_left,
    output logic [DATA_WIDTH-1:0] o_right,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_overrun,
    output logic                  o_frame_err,
    output logic                  o_locked
);

    // Bit counter must reach SLOT_WIDTH+1 so an over-long slot is still detectable.
    localparam int CNT_W = $clog2(SLOT_WIDTH + 2);
    // Comparison constants carry one extra bit so bit_cnt+1 never wraps.
    localparam logic [CNT_W:0]   DW_C  = (CNT_W + 1)'(DATA_WIDTH);
    localparam logic [CNT_W:0]   SW_C  = (CNT_W + 1)'(SLOT_WIDTH);
    localparam logic [CNT_W-1:0] SAT_C = CNT_W'(SLOT_WIDTH + 1);

    typedef enum logic {
        SYNC_WAIT = 1'b0,
        RUN       = 1'b1
    } state_t;

    // Synchroniser stages; the codec pins are treated purely as data.
    logic sclk_meta, sclk_sync, sclk_dly;
    logic lr_meta, lr_sync;
    logic sd_meta, sd_sync;

    logic sclk_rise;
    logic boundary;
    logic lr_prev;

    state_t                state, state_nx;
    logic [DATA_WIDTH-1:0] shift, shift_nx;
    logic [CNT_W-1:0]      bit_cnt, cnt_nx;
    logic [CNT_W:0]        cnt_ext, cnt_inc, pad;
    logic [DATA_WIDTH-1:0] left_hold, left_nx;
    logic [DATA_WIDTH-1:0] word_fin;
    logic                  locked_nx;
    logic                  commit_nx;
    logic                  err_nx;

    // Frame handed from the deserialiser to the output buffer one clk later.
    logic                  commit_pend;
    logic [DATA_WIDTH-1:0] commit_left;
    logic [DATA_WIDTH-1:0] commit_right;

    // Two-flop synchronisers on every pin, plus a delay flop on sclk for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_meta <= 1'b0;
            sclk_sync <= 1'b0;
            sclk_dly  <= 1'b0;
            lr_meta   <= 1'b0;
            lr_sync   <= 1'b0;
            sd_meta   <= 1'b0;
            sd_sync   <= 1'b0;
        end else begin
            sclk_meta <= i2s_sclk;
            sclk_sync <= sclk_meta;
            sclk_dly  <= sclk_sync;
            lr_meta   <= i2s_lrclk;
            lr_sync   <= lr_meta;
            sd_meta   <= i2s_sdata;
            sd_sync   <= sd_meta;
        end
    end

    assign sclk_rise = sclk_sync & ~sclk_dly;
    // Word select changing between two sampled edges marks the last bit of the old word.
    assign boundary  = sclk_rise & (lr_sync != lr_prev);
    assign cnt_ext   = {1'b0, bit_cnt};
    assign cnt_inc   = cnt_ext + 1'b1;

    // Deserialiser state and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= SYNC_WAIT;
            shift        <= '0;
            bit_cnt      <= '0;
            left_hold    <= '0;
            lr_prev      <= 1'b0;
            o_locked     <= 1'b0;
            o_frame_err  <= 1'b0;
            commit_pend  <= 1'b0;
            commit_left  <= '0;
            commit_right <= '0;
        end else begin
            state       <= state_nx;
            shift       <= shift_nx;
            bit_cnt     <= cnt_nx;
            left_hold   <= left_nx;
            o_locked    <= locked_nx;
            o_frame_err <= err_nx;
            commit_pend <= commit_nx;
            if (sclk_rise) begin
                lr_prev <= lr_sync;
            end
            if (commit_nx) begin
                commit_left  <= left_hold;
                commit_right <= word_fin;
            end
        end
    end

    // Next-state logic: lock on the first right-to-left edge, then shift bits and close words at boundaries.
    always_comb begin
        state_nx  = state;
        shift_nx  = shift;
        cnt_nx    = bit_cnt;
        left_nx   = left_hold;
        locked_nx = o_locked;
        commit_nx = 1'b0;
        err_nx    = 1'b0;
        word_fin  = shift;
        pad       = '0;
        case (state)
            SYNC_WAIT: begin
                // The bit on the locking edge belongs to an unseen right word and is discarded.
                if (boundary && !lr_sync) begin
                    state_nx  = RUN;
                    locked_nx = 1'b1;
                    cnt_nx    = '0;
                    shift_nx  = '0;
                end
            end
            RUN: begin
                if (sclk_rise) begin
                    // Bits beyond DATA_WIDTH are counted but not stored.
                    if (cnt_ext < DW_C) begin
                        word_fin = {shift[DATA_WIDTH-2:0], sd_sync};
                    end
                    if (!boundary) begin
                        shift_nx = word_fin;
                        if (bit_cnt != SAT_C) begin
                            cnt_nx = bit_cnt + 1'b1;
                        end
                    end else begin
                        // Short slots are left-justified so the MSB lands in the top bit.
                        if (cnt_inc < DW_C) begin
                            pad      = DW_C - cnt_inc;
                            word_fin = word_fin << pad;
                        end
                        if (cnt_inc > SW_C) begin
                            err_nx = 1'b1;
                        end
                        shift_nx = '0;
                        cnt_nx   = '0;
                        // lr already shows the new channel: 1 means a left word just ended.
                        if (lr_sync) begin
                            left_nx = word_fin;
                        end else begin
                            commit_nx = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_nx = SYNC_WAIT;
            end
        endcase
    end

    // One-entry output buffer: load when empty or being drained, otherwise drop and flag overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_left    <= '0;
            o_right   <= '0;
            o_valid   <= 1'b0;
            o_overrun <= 1'b0;
        end else begin
            o_overrun <= 1'b0;
            if (commit_pend) begin
                if (!o_valid || i_ready) begin
                    o_left  <= commit_left;
                    o_right <= commit_right;
                    o_valid <= 1'b1;
                end else begin
                    o_overrun <= 1'b1;
                end
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule
